// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the front-end blocks.
//   XLEN         : architectural register / address width
//   INSTR_BYTES  : size of one instruction word in bytes (sequential pc step)
//   RESET_VECTOR : pc value loaded by the pc register on reset
//   NOP_INSTR    : canonical no-op (addi x0, x0, 0)
//   word_t       : one XLEN-wide address or instruction word
//   fetch_pair_t : {pc, instr} pair handed from fetch to decode
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_VECTOR = 32'h0000_0000;
    localparam word_t NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_pair_t;

    // Force an address onto an instruction boundary.
    function automatic word_t align_pc(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (empties the queue)
//   push      : write push_data at the tail (caller guarantees !full)
//   push_data : data written on push
//   pop       : drop the head entry (caller guarantees !empty)
//   flush     : empty the queue this edge; overrides push and pop
//   pop_data  : head entry (valid while !empty)
//   full      : DEPTH entries stored
//   empty     : no entries stored
//   count     : number of stored entries, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only the pointers and count do,
    // so the array maps onto plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage between the pc register and decode.
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   pc              : current pc from the pc register
//   pc_next         : value to load into the pc register
//   pc_write_en     : pc register load enable
//   redirect_valid  : taken branch/jump from execute; flush and refetch
//   redirect_pc     : redirect target (low two bits ignored)
//   imem_req_*      : in-order instruction-memory request (addr = pc)
//   imem_rsp_*      : in-order response, no backpressure
//   id_valid/ready  : valid/ready handshake towards decode
//   id_instr, id_pc : instruction word and its pc
// Outstanding requests carry their pc in a tag queue; responses pair with
// the tag head and land in the instruction queue feeding decode. A redirect
// flushes both queues and marks still-in-flight responses to be dropped.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_write_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0] outstanding, outstanding_next;
    logic [CNT_W-1:0] drop_cnt, drop_cnt_next;
    logic [CNT_W-1:0] instr_count, tag_count;
    logic [CNT_W:0]   occupancy;
    logic             credit;
    logic             req_fire, id_fire;
    logic             rsp_keep, rsp_drop;
    logic             tag_full, tag_empty, instr_full, instr_empty;
    word_t            tag_head;
    fetch_pair_t      instr_head;

    // Credit counts every slot that is already promised: requests whose
    // response has not returned plus instructions waiting for decode.
    assign occupancy = {1'b0, outstanding} + {1'b0, instr_count};
    assign credit    = (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    // NOTE: every output of this combinational block gets a default first,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        imem_req_valid = 1'b0;
        pc_write_en    = 1'b0;
        id_valid       = 1'b0;
        pc_next        = pc + XLEN'(INSTR_BYTES);
        if (!rst) begin
            if (redirect_valid) begin
                pc_write_en = 1'b1;
                pc_next     = align_pc(redirect_pc);
            end else begin
                imem_req_valid = credit;
                pc_write_en    = credit & imem_req_ready;
                id_valid       = !instr_empty;
            end
        end
    end

    assign imem_req_addr = pc;
    assign req_fire      = imem_req_valid & imem_req_ready;
    assign id_fire       = id_valid & id_ready;

    // Responses in the redirect cycle are already covered by the drop count
    // computed below, so they are neither kept nor counted as drops here.
    assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop_cnt != '0);

    always_comb begin
        drop_cnt_next    = drop_cnt;
        outstanding_next = outstanding;
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old stream.
            drop_cnt_next    = outstanding - CNT_W'(imem_rsp_valid);
            outstanding_next = drop_cnt_next;
        end else begin
            drop_cnt_next    = drop_cnt - CNT_W'(rsp_drop);
            outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_keep),
        .flush     (redirect_valid),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data ({tag_head, imem_rsp_data}),
        .pop       (id_fire),
        .flush     (redirect_valid),
        .pop_data  (instr_head),
        .full      (instr_full),
        .empty     (instr_empty),
        .count     (instr_count)
    );

    assign id_pc    = instr_head.pc;
    assign id_instr = instr_head.instr;

    // Status outputs that the credit scheme makes redundant here.
    logic unused_status;
    assign unused_status = ^{tag_full, tag_empty, tag_count, instr_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a pc register model, an in-order
// instruction memory with programmable latency, an in-order decode
// scoreboard, a combinational vector table and directed sequences.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc, pc_next, redirect_pc, imem_req_addr, imem_rsp_data;
    logic [31:0] id_instr, id_pc;
    logic        pc_write_en, redirect_valid, imem_req_valid, imem_req_ready;
    logic        imem_rsp_valid, id_valid, id_ready;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(.FIFO_DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_next        (pc_next),
        .pc_write_en    (pc_write_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // pc register model; table mode drives pc directly instead.
    logic [31:0] pc_reg, pc_rst_val = 32'h0, tbl_pc = 32'h0;
    logic        tbl_mode = 1'b0;
    assign pc = tbl_mode ? tbl_pc : pc_reg;

    always @(posedge clk) begin
        if (rst)              pc_reg <= pc_rst_val;
        else if (pc_write_en) pc_reg <= pc_next;
    end

    // In-order memory: response appears 'lat' cycles after the accept edge.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc   = 0;
    int    lat   = 1;
    int    n_req = 0;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            cyc = 0;
        end else begin
            if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{addr: imem_req_addr, due: cyc + lat});
                n_req++;
            end
            cyc++;
        end
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Decode scoreboard: instructions must follow the program order from
    // the reset vector or the latest redirect target.
    logic [31:0] exp_id_pc = 32'h0;
    int          n_id      = 0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_id_pc = pc_rst_val;
        end else if (redirect_valid) begin
            exp_id_pc = {redirect_pc[31:2], 2'b00};
        end else if (id_valid && id_ready) begin
            check("id_pc_order", id_pc, exp_id_pc);
            check("id_instr_pair", id_instr, mem_word(exp_id_pc));
            exp_id_pc = exp_id_pc + 32'd4;
            n_id++;
        end
    end

    // Queue safety: the credit scheme must never push full or pop empty.
    always @(posedge clk) begin
        if (!rst) begin
            check("tag_push_on_full", 32'(u_dut.u_tag_fifo.push && u_dut.u_tag_fifo.full), 32'd0);
            check("tag_pop_on_empty", 32'(u_dut.u_tag_fifo.pop && u_dut.u_tag_fifo.empty), 32'd0);
            check("ins_push_on_full", 32'(u_dut.u_instr_fifo.push && u_dut.u_instr_fifo.full), 32'd0);
            check("ins_pop_on_empty", 32'(u_dut.u_instr_fifo.pop && u_dut.u_instr_fifo.empty), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] pc;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_next;
    } vec_t;

    vec_t vt[6];

    task automatic step();
        @(negedge clk);
    endtask

    // Hold reset for two edges, then release at a falling edge.
    task automatic do_reset(input logic [31:0] rv);
        rst            = 1'b1;
        pc_rst_val     = rv;
        tbl_mode       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n0, n1, id0;

        vt[0] = '{pc: 32'h0000_0000, redir: 0, rpc: 32'h0,         rdy: 1, e_req: 1, e_we: 1, e_next: 32'h0000_0004};
        vt[1] = '{pc: 32'hFFFF_FFFC, redir: 0, rpc: 32'h0,         rdy: 1, e_req: 1, e_we: 1, e_next: 32'h0000_0000};
        vt[2] = '{pc: 32'h0000_0010, redir: 0, rpc: 32'h0,         rdy: 0, e_req: 1, e_we: 0, e_next: 32'h0};
        vt[3] = '{pc: 32'h0000_0020, redir: 1, rpc: 32'h0000_0103, rdy: 1, e_req: 0, e_we: 1, e_next: 32'h0000_0100};
        vt[4] = '{pc: 32'h0000_0030, redir: 1, rpc: 32'hFFFF_FFFF, rdy: 0, e_req: 0, e_we: 1, e_next: 32'hFFFF_FFFC};
        vt[5] = '{pc: 32'h1234_5678, redir: 0, rpc: 32'h0,         rdy: 1, e_req: 1, e_we: 1, e_next: 32'h1234_567C};

        // Reset state: outputs forced low even with a redirect pending.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_pc_we", 32'(pc_write_en), 32'd0);
        check("rst_outstanding", 32'(u_dut.outstanding), 32'd0);

        // Combinational table: each vector applied from a freshly reset state
        // and checked before any clock edge sees it with rst low.
        for (int i = 0; i < 6; i++) begin
            rst = 1'b1;
            step();
            rst            = 1'b0;
            tbl_mode       = 1'b1;
            tbl_pc         = vt[i].pc;
            redirect_valid = vt[i].redir;
            redirect_pc    = vt[i].rpc;
            imem_req_ready = vt[i].rdy;
            #1;
            check($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].e_req));
            check($sformatf("tbl%0d_pc_we", i), 32'(pc_write_en), 32'(vt[i].e_we));
            check($sformatf("tbl%0d_id_valid", i), 32'(id_valid), 32'd0);
            if (vt[i].e_we)  check($sformatf("tbl%0d_pc_next", i), pc_next, vt[i].e_next);
            if (vt[i].e_req) check($sformatf("tbl%0d_req_addr", i), imem_req_addr, vt[i].pc);
            rst = 1'b1;
        end
        tbl_mode = 1'b0;

        // 1: back-to-back fetch with 1-cycle memory, id_valid from cycle 3.
        lat = 1;
        do_reset(32'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("t1_req_valid_c%0d", k), 32'(imem_req_valid), 32'd1);
            check($sformatf("t1_req_addr_c%0d", k), imem_req_addr, 32'(4 * k));
            check($sformatf("t1_pc_we_c%0d", k), 32'(pc_write_en), 32'd1);
            if (k >= 2) begin
                check($sformatf("t1_id_valid_c%0d", k), 32'(id_valid), 32'd1);
                check($sformatf("t1_id_pc_c%0d", k), id_pc, 32'(4 * (k - 2)));
            end else begin
                check($sformatf("t1_id_valid_c%0d", k), 32'(id_valid), 32'd0);
            end
            step();
        end

        // 2: decode stalled -> exactly DEPTH requests, then drain in order.
        lat = 1;
        do_reset(32'h0);
        id_ready = 1'b0;
        n0 = n_req;
        repeat (10) step();
        #1;
        check("t2_req_count_stalled", 32'(n_req - n0), 32'(DEPTH));
        check("t2_req_valid_stalled", 32'(imem_req_valid), 32'd0);
        check("t2_id_valid_stalled", 32'(id_valid), 32'd1);
        check("t2_id_pc_head", id_pc, 32'h0);
        id_ready = 1'b1;
        id0 = n_id;
        n1  = n_req;
        repeat (4) step();
        #1;
        check("t2_drained", 32'(n_id - id0), 32'd4);
        check("t2_fetch_resumed", 32'(n_req - n1), 32'd3);

        // 3: redirect with two requests in flight (3-cycle memory).
        lat = 3;
        do_reset(32'h40);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("t3_outstanding_pre", 32'(u_dut.outstanding), 32'd2);
        check("t3_pc_we", 32'(pc_write_en), 32'd1);
        check("t3_pc_next", pc_next, 32'h100);
        check("t3_req_valid", 32'(imem_req_valid), 32'd0);
        check("t3_id_valid", 32'(id_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (id_valid) break;
            step();
        end
        check("t3_id_valid_after", 32'(id_valid), 32'd1);
        check("t3_first_id_pc", id_pc, 32'h100);
        repeat (6) step();

        // 4: pc wraps from the top of the address space.
        lat = 1;
        do_reset(32'hFFFF_FFF8);
        #1;
        check("t4_addr_start", imem_req_addr, 32'hFFFF_FFF8);
        step();
        #1;
        check("t4_wrap_pc_next", pc_next, 32'h0000_0000);
        check("t4_wrap_pc_we", 32'(pc_write_en), 32'd1);
        id0 = n_id;
        repeat (8) step();
        check("t4_ids_across_wrap", 32'(n_id - id0 >= 4), 32'd1);

        // 5: memory not ready, then intermittent ready with 3-cycle latency.
        lat = 3;
        do_reset(32'h200);
        imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t5_req_valid_c%0d", k), 32'(imem_req_valid), 32'd1);
            check($sformatf("t5_pc_we_c%0d", k), 32'(pc_write_en), 32'd0);
            check($sformatf("t5_pc_hold_c%0d", k), pc, 32'h200);
            check($sformatf("t5_tag_count_c%0d", k), 32'(u_dut.u_tag_fifo.count), 32'd0);
            step();
        end
        id0 = n_id;
        for (int k = 0; k < 30; k++) begin
            imem_req_ready = (k % 3) != 2;
            step();
        end
        check("t5_ids_delivered", 32'(n_id - id0 >= 5), 32'd1);

        // 6: reset while requests are in flight and the queue holds data.
        lat = 3;
        do_reset(32'h300);
        id_ready = 1'b0;
        repeat (12) step();
        #1;
        check("t6_req_valid_full", 32'(imem_req_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_id_valid", 32'(id_valid), 32'd0);
        check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_rst_pc_we", 32'(pc_write_en), 32'd0);
        step();
        #1;
        check("t6_id_valid_after_rst", 32'(id_valid), 32'd0);
        check("t6_req_valid_after_rst", 32'(imem_req_valid), 32'd0);
        check("t6_outstanding_cleared", 32'(u_dut.outstanding), 32'd0);
        lat = 1;
        step();
        rst = 1'b0;
        n0  = n_req;
        repeat (10) step();
        check("t6_credit_restored", 32'(n_req - n0), 32'(DEPTH));
        id_ready = 1'b1;
        id0 = n_id;
        repeat (8) step();
        check("t6_ids_after_rst", 32'(n_id - id0 >= 4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
